id_ex_stage: RTL and testbench

- Pipeline register between decode (register-file read ports) and execute.
- Captures both operands, the immediate, and decoded control for one instruction per cycle.
- Bypasses a same-cycle writeback into the captured operands, since the register file commits writes only at the clock edge.
- Detects load-use hazards and inserts a bubble; supports downstream stall and branch flush.

---
 rtl/id_ex_stage_if.sv | 71 +++++++
 rtl/id_ex_stage.sv | 130 +++++++++++++
 tb/tb_id_ex_stage.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_if.sv
// ----------------------------------------------------------------------------
// id_ex_stage_if
// Bundle between decode, the register file, writeback, execute and the ID/EX
// pipeline register.
//
// Signals
//   decode side : in_valid, in_ready, in_rs, in_rt, in_rd, in_imm, in_alu_op,
//                 in_reg_we, in_mem_re, in_mem_we
//   reg file    : rd1, rd2 (read data for in_rs / in_rt)
//   writeback   : wb_we, wb_addr, wb_data (same-cycle register-file write)
//   control     : stall (downstream hold), flush (taken branch)
//   execute side: ex_valid, ex_op_a, ex_op_b, ex_imm, ex_rs, ex_rt, ex_rd,
//                 ex_alu_op, ex_reg_we, ex_mem_re, ex_mem_we
//   hazard      : load_use_hazard
//
// Modports
//   master : surrounding pipeline (drives decode/rf/wb/control inputs)
//   slave  : the ID/EX stage itself
// ----------------------------------------------------------------------------
interface id_ex_stage_if #(
   parameter int N = 5,
   parameter int M = 32
);
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] in_rs;
   logic [N-1:0] in_rt;
   logic [N-1:0] in_rd;
   logic [M-1:0] rd1;
   logic [M-1:0] rd2;
   logic [M-1:0] in_imm;
   logic [3:0]   in_alu_op;
   logic         in_reg_we;
   logic         in_mem_re;
   logic         in_mem_we;
   logic         wb_we;
   logic [N-1:0] wb_addr;
   logic [M-1:0] wb_data;
   logic         stall;
   logic         flush;
   logic         ex_valid;
   logic [M-1:0] ex_op_a;
   logic [M-1:0] ex_op_b;
   logic [M-1:0] ex_imm;
   logic [N-1:0] ex_rs;
   logic [N-1:0] ex_rt;
   logic [N-1:0] ex_rd;
   logic [3:0]   ex_alu_op;
   logic         ex_reg_we;
   logic         ex_mem_re;
   logic         ex_mem_we;
   logic         load_use_hazard;

   modport master (
      output in_valid, in_rs, in_rt, in_rd, rd1, rd2, in_imm, in_alu_op,
             in_reg_we, in_mem_re, in_mem_we, wb_we, wb_addr, wb_data,
             stall, flush,
      input  in_ready, ex_valid, ex_op_a, ex_op_b, ex_imm, ex_rs, ex_rt,
             ex_rd, ex_alu_op, ex_reg_we, ex_mem_re, ex_mem_we,
             load_use_hazard
   );

   modport slave (
      input  in_valid, in_rs, in_rt, in_rd, rd1, rd2, in_imm, in_alu_op,
             in_reg_we, in_mem_re, in_mem_we, wb_we, wb_addr, wb_data,
             stall, flush,
      output in_ready, ex_valid, ex_op_a, ex_op_b, ex_imm, ex_rs, ex_rt,
             ex_rd, ex_alu_op, ex_reg_we, ex_mem_re, ex_mem_we,
             load_use_hazard
   );
endinterface

// File: rtl/id_ex_stage.sv
// ----------------------------------------------------------------------------
// id_ex_stage
// Pipeline register between decode and execute. Captures both operands, the
// immediate, register numbers and decoded control once per cycle. A writeback
// landing in the same cycle is bypassed into the captured operands because the
// register file only commits on the clock edge. A load followed by a dependent
// instruction produces one bubble; stall holds the stage, flush empties it.
//
// Ports
//   clk   : system clock, all state on posedge
//   rst_n : asynchronous active-low reset, clears every ex_* output
//   bus   : id_ex_stage_if.slave (decode, reg file, writeback, control,
//           execute-side outputs, load_use_hazard, in_ready)
// ----------------------------------------------------------------------------
module id_ex_stage #(
   parameter int N = 5,
   parameter int M = 32
) (
   input logic          clk,
   input logic          rst_n,
   id_ex_stage_if.slave bus
);

   // Register 0 reads as zero; a matching writeback beats the stale read data.
   // wb_addr==0 can never bypass since src==0 is resolved first.
   function automatic logic [M-1:0] sel_operand(
      input logic [N-1:0] src,
      input logic [M-1:0] rf_data,
      input logic         wb_we,
      input logic [N-1:0] wb_addr,
      input logic [M-1:0] wb_data
   );
      if (src == '0)
         return '0;
      else if (wb_we && (wb_addr == src))
         return wb_data;
      else
         return rf_data;
   endfunction

   // ---- p0: operand select / hazard detect (combinational) ----
   logic [M-1:0] op_a_p0;
   logic [M-1:0] op_b_p0;
   logic         hazard_p0;
   logic         clear_p0;
   logic         load_p0;

   // ---- p1: captured ID/EX state ----
   logic         vld_p1;
   logic [M-1:0] op_a_p1;
   logic [M-1:0] op_b_p1;
   logic [M-1:0] imm_p1;
   logic [N-1:0] rs_p1;
   logic [N-1:0] rt_p1;
   logic [N-1:0] rd_p1;
   logic [3:0]   alu_op_p1;
   logic         reg_we_p1;
   logic         mem_re_p1;
   logic         mem_we_p1;

   always_comb begin
      op_a_p0 = sel_operand(bus.in_rs, bus.rd1, bus.wb_we, bus.wb_addr, bus.wb_data);
      op_b_p0 = sel_operand(bus.in_rt, bus.rd2, bus.wb_we, bus.wb_addr, bus.wb_data);

      hazard_p0 = vld_p1 & mem_re_p1 & (rd_p1 != '0) & bus.in_valid &
                  ((rd_p1 == bus.in_rs) | (rd_p1 == bus.in_rt));

      // flush wins over stall; a bubble is only inserted when not stalled.
      clear_p0 = bus.flush | (~bus.stall & hazard_p0);
      load_p0  = ~bus.flush & ~bus.stall & ~hazard_p0;
   end

   assign bus.load_use_hazard = hazard_p0;
   assign bus.in_ready        = ~bus.stall & ~hazard_p0;

   // ---- p0 -> p1 boundary ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1    <= 1'b0;
         op_a_p1   <= '0;
         op_b_p1   <= '0;
         imm_p1    <= '0;
         rs_p1     <= '0;
         rt_p1     <= '0;
         rd_p1     <= '0;
         alu_op_p1 <= '0;
         reg_we_p1 <= 1'b0;
         mem_re_p1 <= 1'b0;
         mem_we_p1 <= 1'b0;
      end else if (clear_p0) begin
         vld_p1    <= 1'b0;
         op_a_p1   <= '0;
         op_b_p1   <= '0;
         imm_p1    <= '0;
         rs_p1     <= '0;
         rt_p1     <= '0;
         rd_p1     <= '0;
         alu_op_p1 <= '0;
         reg_we_p1 <= 1'b0;
         mem_re_p1 <= 1'b0;
         mem_we_p1 <= 1'b0;
      end else if (load_p0) begin
         vld_p1    <= bus.in_valid;
         op_a_p1   <= op_a_p0;
         op_b_p1   <= op_b_p0;
         imm_p1    <= bus.in_imm;
         rs_p1     <= bus.in_rs;
         rt_p1     <= bus.in_rt;
         rd_p1     <= bus.in_rd;
         alu_op_p1 <= bus.in_alu_op;
         // An invalid slot must never carry live side-effect controls.
         reg_we_p1 <= bus.in_valid & bus.in_reg_we;
         mem_re_p1 <= bus.in_valid & bus.in_mem_re;
         mem_we_p1 <= bus.in_valid & bus.in_mem_we;
      end
   end

   assign bus.ex_valid  = vld_p1;
   assign bus.ex_op_a   = op_a_p1;
   assign bus.ex_op_b   = op_b_p1;
   assign bus.ex_imm    = imm_p1;
   assign bus.ex_rs     = rs_p1;
   assign bus.ex_rt     = rt_p1;
   assign bus.ex_rd     = rd_p1;
   assign bus.ex_alu_op = alu_op_p1;
   assign bus.ex_reg_we = reg_we_p1;
   assign bus.ex_mem_re = mem_re_p1;
   assign bus.ex_mem_we = mem_we_p1;

endmodule

// File: tb/tb_id_ex_stage.sv
// ----------------------------------------------------------------------------
// tb_id_ex_stage
// Directed bench for id_ex_stage. Expected ex_* records are queued when the
// stimulus is driven and popped after the capturing edge.
// ----------------------------------------------------------------------------
module tb_id_ex_stage;

   logic clk;
   logic rst_n;

   id_ex_stage_if #(.N(5), .M(32)) bus ();

   id_ex_stage #(.N(5), .M(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        vld;
      logic [31:0] op_a;
      logic [31:0] op_b;
      logic [31:0] imm;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [3:0]  alu;
      logic        reg_we;
      logic        mem_re;
      logic        mem_we;
   } rec_t;

   typedef struct {
      rec_t e;
      rec_t m;
   } sb_t;

   sb_t  sbq[$];
   int   total = 0;
   int   bad   = 0;
   rec_t all_m;
   rec_t ctrl_m;
   rec_t zero_r;
   rec_t dep_r;

   function automatic rec_t mk(input logic v, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] imm, input logic [4:0] rs,
                               input logic [4:0] rt, input logic [4:0] rd,
                               input logic [3:0] alu, input logic we,
                               input logic re, input logic mwe);
      rec_t r;
      r.vld = v; r.op_a = a; r.op_b = b; r.imm = imm;
      r.rs = rs; r.rt = rt; r.rd = rd; r.alu = alu;
      r.reg_we = we; r.mem_re = re; r.mem_we = mwe;
      return r;
   endfunction

   function automatic rec_t act();
      return mk(bus.ex_valid, bus.ex_op_a, bus.ex_op_b, bus.ex_imm, bus.ex_rs,
                bus.ex_rt, bus.ex_rd, bus.ex_alu_op, bus.ex_reg_we,
                bus.ex_mem_re, bus.ex_mem_we);
   endfunction

   task automatic dec(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [31:0] r1, input logic [31:0] r2,
                      input logic [31:0] imm, input logic [3:0] alu, input logic we,
                      input logic re, input logic mwe);
      bus.in_valid = v; bus.in_rs = rs; bus.in_rt = rt; bus.in_rd = rd;
      bus.rd1 = r1; bus.rd2 = r2; bus.in_imm = imm; bus.in_alu_op = alu;
      bus.in_reg_we = we; bus.in_mem_re = re; bus.in_mem_we = mwe;
   endtask

   task automatic wb(input logic we, input logic [4:0] addr, input logic [31:0] data);
      bus.wb_we = we; bus.wb_addr = addr; bus.wb_data = data;
   endtask

   task automatic push(input rec_t e, input rec_t m);
      sb_t s;
      s.e = e;
      s.m = m;
      sbq.push_back(s);
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic pop_check(input string tag);
      sb_t  s;
      rec_t a;
      total++;
      if (sbq.size() == 0) begin
         bad++;
         $error("FAIL %s: scoreboard empty, nothing expected", tag);
      end else begin
         s = sbq.pop_front();
         a = act();
         assert ((a & s.m) === (s.e & s.m))
         else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, a & s.m, s.e & s.m);
         end
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   initial begin
      all_m  = '1;
      ctrl_m = '0;
      ctrl_m.vld = 1'b1; ctrl_m.reg_we = 1'b1; ctrl_m.mem_re = 1'b1; ctrl_m.mem_we = 1'b1;
      zero_r = '0;

      rst_n = 1'b0;
      bus.stall = 1'b0;
      bus.flush = 1'b0;
      dec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      wb(0, 0, 0);
      repeat (2) cycle();
      push(zero_r, all_m);
      pop_check("reset_state");
      rst_n = 1'b1;

      // writeback bypass into operand A
      dec(1, 5, 7, 9, 32'h11111111, 32'h22222222, 32'h100, 4'd3, 1, 0, 0);
      wb(1, 5, 32'hDEADBEEF);
      push(mk(1, 32'hDEADBEEF, 32'h22222222, 32'h100, 5, 7, 9, 3, 1, 0, 0), all_m);
      cycle();
      pop_check("wb_bypass_a");

      // no match on A, match on B
      dec(1, 5, 6, 10, 32'h11111111, 32'h22222222, 32'h200, 4'd4, 0, 0, 1);
      wb(1, 6, 32'hCAFEF00D);
      push(mk(1, 32'h11111111, 32'hCAFEF00D, 32'h200, 5, 6, 10, 4, 0, 0, 1), all_m);
      cycle();
      pop_check("wb_nomatch_a_bypass_b");

      // register 0 is always zero, even with a wb to r0
      dec(1, 0, 0, 11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h300, 4'd5, 1, 0, 0);
      wb(1, 0, 32'h5);
      push(mk(1, 0, 0, 32'h300, 0, 0, 11, 5, 1, 0, 0), all_m);
      cycle();
      pop_check("zero_reg");

      // matching address but wb_we low
      dec(1, 5, 5, 12, 32'h11111111, 32'h33333333, 32'h400, 4'd6, 1, 0, 0);
      wb(0, 5, 32'hDEADBEEF);
      push(mk(1, 32'h11111111, 32'h33333333, 32'h400, 5, 5, 12, 6, 1, 0, 0), all_m);
      cycle();
      pop_check("wb_we_low");

      // load to r3, then dependent use of r3
      dec(1, 1, 2, 3, 32'hA1A1A1A1, 32'hA2A2A2A2, 32'h4, 4'd0, 1, 1, 0);
      wb(0, 0, 0);
      push(mk(1, 32'hA1A1A1A1, 32'hA2A2A2A2, 32'h4, 1, 2, 3, 0, 1, 1, 0), all_m);
      cycle();
      pop_check("load");
      dec(1, 4, 3, 8, 32'hB1B1B1B1, 32'hB2B2B2B2, 32'h8, 4'd2, 1, 0, 0);
      #1;
      chk1("hazard_set", bus.load_use_hazard, 1'b1);
      chk1("in_ready_hazard", bus.in_ready, 1'b0);
      push(zero_r, all_m);
      cycle();
      pop_check("bubble");
      chk1("hazard_clear", bus.load_use_hazard, 1'b0);
      chk1("in_ready_after_bubble", bus.in_ready, 1'b1);
      dep_r = mk(1, 32'hB1B1B1B1, 32'hB2B2B2B2, 32'h8, 4, 3, 8, 2, 1, 0, 0);
      push(dep_r, all_m);
      cycle();
      pop_check("dep_capture");

      // stall three cycles while inputs and writeback to rs change
      bus.stall = 1'b1;
      #1;
      chk1("in_ready_stall", bus.in_ready, 1'b0);
      for (int i = 0; i < 3; i++) begin
         dec(1, 5'(i + 1), 5'(i + 2), 5'(i + 13), $urandom, $urandom, 32'(i), 4'd7, 1, 1, 1);
         wb(1, 4, 32'hFFFF0000 + 32'(i));
         push(dep_r, all_m);
         cycle();
         pop_check("stall_hold");
      end
      bus.stall = 1'b0;
      dec(1, 7, 8, 9, 32'hC1C1C1C1, 32'hC2C2C2C2, 32'hC3C3C3C3, 4'd9, 1, 0, 0);
      wb(0, 0, 0);
      push(mk(1, 32'hC1C1C1C1, 32'hC2C2C2C2, 32'hC3C3C3C3, 7, 8, 9, 9, 1, 0, 0), all_m);
      cycle();
      pop_check("after_stall");

      // flush together with stall empties the stage
      bus.stall = 1'b1;
      bus.flush = 1'b1;
      dec(1, 1, 2, 3, 32'h1, 32'h2, 32'h3, 4'd1, 1, 1, 1);
      #1;
      chk1("in_ready_flush_stall", bus.in_ready, 1'b0);
      push(zero_r, ctrl_m);
      cycle();
      pop_check("flush_over_stall");
      bus.flush = 1'b0;
      chk1("in_ready_still_stalled", bus.in_ready, 1'b0);
      push(zero_r, ctrl_m);
      cycle();
      pop_check("flushed_held");
      bus.stall = 1'b0;

      // capture of an invalid slot drops controls
      dec(0, 1, 2, 3, 32'hD1, 32'hD2, 32'hD3, 4'd5, 1, 1, 1);
      push(zero_r, ctrl_m);
      cycle();
      pop_check("invalid_capture");

      // load into r0 never raises a hazard
      dec(1, 1, 1, 0, 32'hE1, 32'hE2, 32'hE3, 4'd0, 1, 1, 0);
      push(mk(1, 32'hE1, 32'hE2, 32'hE3, 1, 1, 0, 0, 1, 1, 0), all_m);
      cycle();
      pop_check("load_r0");
      dec(1, 0, 0, 5, 32'hF1, 32'hF2, 32'hF3, 4'd8, 1, 0, 0);
      #1;
      chk1("no_hazard_r0", bus.load_use_hazard, 1'b0);
      push(mk(1, 0, 0, 32'hF3, 0, 0, 5, 8, 1, 0, 0), all_m);
      cycle();
      pop_check("r0_capture");

      // asynchronous reset mid-stream with ex_valid=1
      #2;
      rst_n = 1'b0;
      #1;
      push(zero_r, all_m);
      pop_check("async_reset");
      cycle();
      push(zero_r, all_m);
      pop_check("reset_hold");
      rst_n = 1'b1;
      dec(1, 2, 3, 4, 32'h12345678, 32'h9ABCDEF0, 32'h55, 4'd1, 1, 0, 0);
      push(mk(1, 32'h12345678, 32'h9ABCDEF0, 32'h55, 2, 3, 4, 1, 1, 0, 0), all_m);
      cycle();
      pop_check("first_after_reset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
